// File: rtl/ysyx_24100005_rf_pkg.sv
// Shared defaults and helpers for the multi-port register file with busy scoreboard.
// Optional same-cycle write bypass is enabled by defining YSYX_24100005_RF_BYPASS_EN.
package ysyx_24100005_rf_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NR_READ    = 2;

    function automatic int lane_count(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ysyx_24100005_rf_read_port.sv
// One combinational read port: index mux, hardwired-zero gate and, when
// YSYX_24100005_RF_BYPASS_EN is defined, a merge of the in-flight write.
module ysyx_24100005_rf_read_port
    import ysyx_24100005_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ZERO_REG   = 1,
    parameter int DEPTH      = 2 ** ADDR_WIDTH,
    parameter int LANES      = DATA_WIDTH / 8
) (
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] mem [DEPTH],
    input  logic [DEPTH-1:0]      busy,
`ifdef YSYX_24100005_RF_BYPASS_EN
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [LANES-1:0]      wmask,
    input  logic                  issue_en,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
`endif
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rbusy
);

    logic is_zero;
    assign is_zero = (ZERO_REG != 0) && (raddr == '0);

`ifdef YSYX_24100005_RF_BYPASS_EN
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] stored,
        input logic [DATA_WIDTH-1:0] wr_data,
        input logic [LANES-1:0]      mask
    );
        logic [DATA_WIDTH-1:0] res;
        res = stored;
        for (int k = 0; k < LANES; k++) begin
            if (mask[k]) res[8*k +: 8] = wr_data[8*k +: 8];
        end
        return res;
    endfunction

    logic hit;
    assign hit = wen && (raddr == waddr);
`endif

    always_comb begin
        rdata = mem[raddr];
        rbusy = busy[raddr];
`ifdef YSYX_24100005_RF_BYPASS_EN
        // The write clears busy this edge; only a coincident issue keeps it set.
        if (hit) begin
            rdata = merge_lanes(mem[raddr], wdata, wmask);
            rbusy = issue_en && (issue_addr == raddr);
        end
`endif
        if (is_zero) begin
            rdata = '0;
            rbusy = 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_24100005_regfile_mp.sv
// Byte-maskable register file with NR_READ combinational read ports and a per-entry
// busy scoreboard. Define YSYX_24100005_RF_BYPASS_EN for same-cycle write forwarding.
module ysyx_24100005_regfile_mp
    import ysyx_24100005_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NR_READ    = DEF_NR_READ,
    parameter int ZERO_REG   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wen,
    input  logic [ADDR_WIDTH-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [DATA_WIDTH/8-1:0]       wmask,
    input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NR_READ*DATA_WIDTH-1:0] rdata,
    output logic [NR_READ-1:0]            rbusy,
    input  logic                          issue_en,
    input  logic [ADDR_WIDTH-1:0]         issue_addr,
    output logic                          any_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANES = lane_count(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_nxt;
    logic                  wr_ok;
    logic                  iss_ok;

    assign wr_ok  = wen && !((ZERO_REG != 0) && (waddr == '0));
    assign iss_ok = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));

    // Clear first, then set, so a coincident issue to the written entry wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok)  busy_nxt[waddr]      = 1'b0;
        if (iss_ok) busy_nxt[issue_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_ok) begin
                for (int k = 0; k < LANES; k++) begin
                    if (wmask[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
            busy <= busy_nxt;
        end
    end

    assign any_busy = |busy;

`ifdef YSYX_24100005_RF_BYPASS_EN
    // Forwarding is masked while reset holds the array at zero.
    logic byp_wen;
    logic byp_issue;
    assign byp_wen   = wr_ok && rst;
    assign byp_issue = iss_ok && rst;
`endif

    for (genvar p = 0; p < NR_READ; p++) begin : g_rd
        ysyx_24100005_rf_read_port #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .ZERO_REG   (ZERO_REG),
            .DEPTH      (DEPTH),
            .LANES      (LANES)
        ) u_port (
            .raddr      (raddr[ADDR_WIDTH*p +: ADDR_WIDTH]),
            .mem        (mem),
            .busy       (busy),
`ifdef YSYX_24100005_RF_BYPASS_EN
            .wen        (byp_wen),
            .waddr      (waddr),
            .wdata      (wdata),
            .wmask      (wmask),
            .issue_en   (byp_issue),
            .issue_addr (issue_addr),
`endif
            .rdata      (rdata[DATA_WIDTH*p +: DATA_WIDTH]),
            .rbusy      (rbusy[p])
        );
    end

endmodule

// File: tb/tb_ysyx_24100005_regfile_mp.sv
// Scoreboard bench for ysyx_24100005_regfile_mp with four read ports; expectations
// follow the bypass build when YSYX_24100005_RF_BYPASS_EN is defined.
module tb_ysyx_24100005_regfile_mp;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 4;
`ifdef YSYX_24100005_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wen = 1'b0;
    logic [AW-1:0]    waddr = '0;
    logic [DW-1:0]    wdata = '0;
    logic [DW/8-1:0]  wmask = '0;
    logic [NR*AW-1:0] raddr = '0;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic             issue_en = 1'b0;
    logic [AW-1:0]    issue_addr = '0;
    logic             any_busy;

    ysyx_24100005_regfile_mp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NR_READ    (NR),
        .ZERO_REG   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .wmask      (wmask),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .any_busy   (any_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        bsy;
        logic        any;
        logic [95:0] tag;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Monitor: at every falling edge, drain expectations issued this cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] got;
            e   = q.pop_front();
            got = rdata[e.port*DW +: DW];
            n_chk++;
            if (got !== e.data) begin
                n_fail++;
                $display("FAIL %0s data p%0d: got %h want %h", e.tag, e.port, got, e.data);
            end
            n_chk++;
            if (rbusy[e.port] !== e.bsy) begin
                n_fail++;
                $display("FAIL %0s rbusy p%0d: got %b want %b", e.tag, e.port, rbusy[e.port], e.bsy);
            end
            n_chk++;
            if (any_busy !== e.any) begin
                n_fail++;
                $display("FAIL %0s any_busy: got %b want %b", e.tag, any_busy, e.any);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen      = 1'b0;
        wmask    = '0;
        issue_en = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        wmask = m;
    endtask

    task automatic iss(input logic [AW-1:0] a);
        issue_en   = 1'b1;
        issue_addr = a;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        raddr[p*AW +: AW] = a;
    endtask

    task automatic push_exp(input int p, input logic [31:0] d, input logic b,
                            input logic a, input logic [95:0] tag);
        exp_t e;
        e.port = p;
        e.data = d;
        e.bsy  = b;
        e.any  = a;
        e.tag  = tag;
        q.push_back(e);
    endtask

    initial begin
        #1 rst = 1'b0;
        cyc();
        rd(0, 5'd5);
        push_exp(0, 32'h0, 1'b0, 1'b0, "rst_init");
        cyc();
        rst = 1'b1;

        // Write and issue the same entry: data lands, busy ends set.
        cyc();
        wr(5'd5, 32'hDEADBEEF, 4'hF);
        iss(5'd5);
        push_exp(0, BYP ? 32'hDEADBEEF : 32'h0, BYP, 1'b0, "wr5_pre");
        cyc();
        idle();
        push_exp(0, 32'hDEADBEEF, 1'b1, 1'b1, "wr5_post");

        // Mid-cycle asynchronous reset, with a write/issue that must be dropped.
        cyc();
        #2;
        rst = 1'b0;
        wr(5'd5, 32'hCAFEF00D, 4'hF);
        iss(5'd6);
        rd(1, 5'd6);
        push_exp(0, 32'h0, 1'b0, 1'b0, "rst_async");
        push_exp(1, 32'h0, 1'b0, 1'b0, "rst_async6");
        cyc();
        idle();
        rst = 1'b1;
        push_exp(0, 32'h0, 1'b0, 1'b0, "rst_drop5");
        push_exp(1, 32'h0, 1'b0, 1'b0, "rst_drop6");

        // Byte-masked write.
        cyc();
        wr(5'd3, 32'h11223344, 4'hF);
        rd(1, 5'd3);
        push_exp(1, BYP ? 32'h11223344 : 32'h0, 1'b0, 1'b0, "wr3_full");
        cyc();
        wr(5'd3, 32'hAABBCCDD, 4'b0101);
        push_exp(1, BYP ? 32'h11BB33DD : 32'h11223344, 1'b0, 1'b0, "wr3_mask");
        cyc();
        idle();
        push_exp(1, 32'h11BB33DD, 1'b0, 1'b0, "mask_res");

        // Hardwired zero entry ignores writes and issues.
        cyc();
        wr(5'd0, 32'hFFFFFFFF, 4'hF);
        iss(5'd0);
        rd(0, 5'd0);
        push_exp(0, 32'h0, 1'b0, 1'b0, "zero_pre");
        cyc();
        idle();
        push_exp(0, 32'h0, 1'b0, 1'b0, "zero_post");

        // Busy scoreboard on entry 7.
        cyc();
        iss(5'd7);
        rd(2, 5'd7);
        push_exp(2, 32'h0, 1'b0, 1'b0, "iss7_pre");
        cyc();
        wr(5'd7, 32'h00000077, 4'hF);
        iss(5'd7);
        push_exp(2, BYP ? 32'h77 : 32'h0, 1'b1, 1'b1, "wr_iss7");
        cyc();
        idle();
        wr(5'd7, 32'h00000078, 4'hF);
        push_exp(2, BYP ? 32'h78 : 32'h77, BYP ? 1'b0 : 1'b1, 1'b1, "wr7_only");
        cyc();
        idle();
        push_exp(2, 32'h78, 1'b0, 1'b0, "clr7");

        // Write and issue to different entries; zero-mask write still clears busy.
        cyc();
        wr(5'd3, 32'hFFFFFFFF, 4'h0);
        iss(5'd8);
        rd(3, 5'd8);
        push_exp(1, 32'h11BB33DD, 1'b0, 1'b0, "mask0_pre");
        cyc();
        idle();
        push_exp(1, 32'h11BB33DD, 1'b0, 1'b1, "mask0_keep");
        push_exp(3, 32'h0, 1'b1, 1'b1, "iss8");
        cyc();
        iss(5'd8);
        issue_en = 1'b1;
        push_exp(3, 32'h0, 1'b1, 1'b1, "reiss8");
        cyc();
        idle();
        wr(5'd8, 32'hFFFFFFFF, 4'h0);
        push_exp(3, 32'h0, BYP ? 1'b0 : 1'b1, 1'b1, "clr8_pre");
        cyc();
        idle();
        push_exp(3, 32'h0, 1'b0, 1'b0, "clr8_post");

        // Bypass visibility on entry 9.
        cyc();
        wr(5'd9, 32'h12345678, 4'hF);
        rd(1, 5'd9);
        push_exp(1, BYP ? 32'h12345678 : 32'h0, 1'b0, 1'b0, "byp9_pre");
        cyc();
        idle();
        push_exp(1, 32'h12345678, 1'b0, 1'b0, "byp9_post");

        // Multi-port: distinct and duplicate indices.
        rd(0, 5'd3);
        rd(2, 5'd9);
        rd(3, 5'd5);
        cyc();
        push_exp(0, 32'h11BB33DD, 1'b0, 1'b0, "mp_p0");
        push_exp(1, 32'h12345678, 1'b0, 1'b0, "mp_p1");
        push_exp(2, 32'h12345678, 1'b0, 1'b0, "mp_p2");
        push_exp(3, 32'h0, 1'b0, 1'b0, "mp_p3");
        cyc();
        wr(5'd31, 32'hA5A5A5A5, 4'hF);
        cyc();
        idle();
        for (int p = 0; p < NR; p++) rd(p, 5'd31);
        cyc();
        for (int p = 0; p < NR; p++) push_exp(p, 32'hA5A5A5A5, 1'b0, 1'b0, "mp_dup31");
        cyc();
        cyc();

        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_24100005_regfile_mp.md
YSYX_24100005_REGFILE_MP -- requirements
Module: ysyx_24100005_regfile_mp

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register index width; depth = 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 32, register width; SHALL be a multiple of 8.
REQ-003 Parameter NR_READ, default 2, number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, when 1 entry 0 is hardwired to zero and never busy.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-low.
REQ-007 wen  input  1  write enable.
REQ-008 waddr  input  ADDR_WIDTH  write index.
REQ-009 wdata  input  DATA_WIDTH  write data.
REQ-010 wmask  input  DATA_WIDTH/8  byte-lane write mask, bit k covers wdata[8k+7:8k].
REQ-011 raddr  input  NR_READ*ADDR_WIDTH  packed read indices, port p at [ADDR_WIDTH*(p+1)-1:ADDR_WIDTH*p].
REQ-012 rdata  output  NR_READ*DATA_WIDTH  packed read data, same packing rule.
REQ-013 rbusy  output  NR_READ  busy flag of the entry addressed by each read port.
REQ-014 issue_en  input  1  marks entry issue_addr busy (pending writeback).
REQ-015 issue_addr  input  ADDR_WIDTH  index to mark busy.
REQ-016 any_busy  output  1  OR of all busy bits.

Function
REQ-017 Write: on rising clk with wen=1, each byte lane of entry waddr with wmask bit=1 SHALL take the wdata lane; unmasked lanes keep their value.
REQ-018 Write with wmask all-zero SHALL leave data unchanged but still clear busy (REQ-021).
REQ-019 Reads SHALL be combinational, zero latency; all ports independent, any index including duplicates.
REQ-020 ZERO_REG=1: read of index 0 returns 0 and rbusy=0; writes and issues to index 0 SHALL be ignored.
REQ-021 Busy scoreboard: one bit per entry; issue_en sets bit issue_addr at clock edge; wen clears bit waddr at clock edge.
REQ-022 Same-cycle wen and issue_en to the same index: bit SHALL end set (new issue wins); data write still performed.
REQ-023 Same-cycle wen and issue_en to different indices: both actions SHALL occur.
REQ-024 issue_en on an already-busy entry SHALL keep it busy (no counting).
REQ-025 rbusy and any_busy SHALL reflect registered busy bits (current-cycle state, no bypass of issue_en).
REQ-026 Depth wrap: indices are full-range; no out-of-range case exists.

Reset
REQ-027 rst low SHALL immediately clear all entries to 0 and all busy bits to 0, independent of clk.
REQ-028 Outputs during/after reset: rdata all 0, rbusy all 0, any_busy 0.
REQ-029 Write or issue coincident with reset assertion SHALL be discarded; first update occurs on first rising clk after rst goes high.

Configuration
REQ-030 Macro YSYX_24100005_RF_BYPASS_EN defined: when wen=1 and raddr of port p equals waddr (and not hardwired zero), rdata[p] SHALL return the merged value (masked wdata lanes over stored lanes) in the same cycle, and rbusy[p] SHALL read 0 unless issue for that index is pending in the stored busy bit after the merge rule of REQ-022 (i.e. rbusy[p]=0 when write clears it this cycle).
REQ-031 Macro undefined: reads SHALL return stored contents only; written value visible from the cycle after the write edge.

Structure
REQ-032 Package ysyx_24100005_rf_pkg SHALL hold default ADDR_WIDTH, DATA_WIDTH, NR_READ constants and the byte-lane count function.
REQ-033 One sub-module ysyx_24100005_rf_read_port (index mux, zero-reg gate, optional bypass merge), instantiated NR_READ times via generate.

Verification
REQ-034 Reset: write 0xDEADBEEF to entry 5, pulse rst low mid-cycle -> rdata for index 5 = 0 immediately, any_busy=0.
REQ-035 Masked write: entry 3 = 0x11223344, write 0xAABBCCDD wmask=4'b0101 -> read 0x11BB33DD next cycle.
REQ-036 Zero reg: write 0xFFFFFFFF to 0, issue_en to 0 -> rdata port0 index 0 = 0, rbusy=0, any_busy=0.
REQ-037 Scoreboard: issue 7 -> rbusy=1 next cycle; same cycle wen to 7 and issue 7 -> remains busy; wen to 7 alone -> rbusy=0 next cycle.
REQ-038 Bypass (macro defined): entry 9=0, wen 9 data 0x12345678 full mask, raddr port1=9 same cycle -> rdata port1 = 0x12345678 before edge; macro undefined -> 0 before edge, 0x12345678 after.
REQ-039 Multi-port: NR_READ=4, all ports address distinct and duplicate indices -> each returns its stored value with no cross-port interference.
